// File: rtl/btn_press_encoder.sv
// Keypad front end: synchronises and debounces four push-buttons, then emits
// one strobe with the captured pattern for each new press after a full release.
module btn_press_encoder #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn_raw,
   output logic [3:0] btn,
   output logic       is_a_key_pressed,
   output logic       key_held
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      INIT    = 2'd0,
      IDLE    = 2'd1,
      PRESSED = 2'd2
   } state_t;

   logic [3:0]       s1;
   logic [3:0]       s2;
   logic [3:0]       cand;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       deb;
   state_t           state;
   state_t           next_state;
   logic             load_press;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 4'd0;
         s2 <= 4'd0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
      end
   end

   // deb resets to all-ones so a button held through reset looks "already
   // pressed" and can never produce a strobe until it is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand <= 4'd0;
         cnt  <= '0;
         deb  <= 4'hF;
      end else if (s2 != cand) begin
         cand <= s2;
         cnt  <= '0;
      end else if (cand != deb) begin
         if (cnt == CNT_MAX) begin
            deb <= cand;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= INIT;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      load_press = 1'b0;
      unique case (state)
         INIT:    if (deb == 4'd0) next_state = IDLE;
         IDLE:    if (deb != 4'd0) begin
                     next_state = PRESSED;
                     load_press = 1'b1;
                  end
         PRESSED: if (deb == 4'd0) next_state = IDLE;
         default: next_state = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn              <= 4'd0;
         is_a_key_pressed <= 1'b0;
      end else begin
         is_a_key_pressed <= load_press;
         if (load_press) btn <= deb;
      end
   end

   always_comb begin
      key_held = (state == PRESSED);
   end

endmodule

// File: tb/tb_btn_press_encoder.sv
// Directed bench for btn_press_encoder with DEBOUNCE_CYCLES = 4 (press latency 8 edges).
module tb_btn_press_encoder;

   logic       clk;
   logic       rst_n;
   logic [3:0] btn_raw;
   logic [3:0] btn;
   logic       is_a_key_pressed;
   logic       key_held;

   int         n_compared;
   int         n_mismatched;
   int         strobe_count;
   logic [3:0] strobe_codes[$];
   int         base;

   btn_press_encoder #(.DEBOUNCE_CYCLES(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .btn_raw          (btn_raw),
      .btn              (btn),
      .is_a_key_pressed (is_a_key_pressed),
      .key_held         (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log every strobe so whole-run counts and code order can be checked.
   always @(posedge clk) begin
      if (is_a_key_pressed) begin
         strobe_count = strobe_count + 1;
         strobe_codes.push_back(btn);
      end
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared = n_compared + 1;
      if (got !== exp) begin
         n_mismatched = n_mismatched + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_and_check(input logic [3:0] code, input string tag);
      btn_raw = code;
      tick(7);
      check_output({tag, "_no_early_strobe"}, is_a_key_pressed, 1'b0);
      tick(1);
      check_output({tag, "_strobe"}, is_a_key_pressed, 1'b1);
      check_output({tag, "_btn"}, btn, code);
      check_output({tag, "_held"}, key_held, 1'b1);
      tick(1);
      check_output({tag, "_strobe_width"}, is_a_key_pressed, 1'b0);
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      strobe_count = 0;
      rst_n        = 1'b0;
      btn_raw      = 4'd0;

      // Reset state
      tick(3);
      check_output("rst_btn", btn, 4'd0);
      check_output("rst_strobe", is_a_key_pressed, 1'b0);
      check_output("rst_held", key_held, 1'b0);
      rst_n = 1'b1;
      tick(12);
      check_output("arm_held", key_held, 1'b0);
      check_output("arm_no_strobe", strobe_count, 0);

      // Clean press of 0100 held 20 cycles
      base = strobe_count;
      press_and_check(4'b0100, "clean");
      tick(11);
      check_output("clean_still_held", key_held, 1'b1);
      btn_raw = 4'd0;
      tick(7);
      check_output("clean_rel_held_e7", key_held, 1'b1);
      tick(1);
      check_output("clean_rel_idle_e8", key_held, 1'b0);
      check_output("clean_btn_kept", btn, 4'b0100);
      check_output("clean_one_strobe", strobe_count - base, 1);

      // Bounce rejection
      base = strobe_count;
      for (int i = 0; i < 3; i++) begin
         btn_raw = 4'b0001;
         tick(2);
         btn_raw = 4'b0000;
         tick(2);
      end
      check_output("bounce_no_strobe", strobe_count - base, 0);
      check_output("bounce_not_held", key_held, 1'b0);
      press_and_check(4'b0001, "bounce");
      btn_raw = 4'd0;
      tick(12);
      check_output("bounce_one_strobe", strobe_count - base, 1);

      // Chord while held, then re-press after full release
      base = strobe_count;
      press_and_check(4'b0010, "chord1");
      tick(2);
      btn_raw = 4'b0011;
      tick(12);
      check_output("chord_no_extra_strobe", strobe_count - base, 1);
      check_output("chord_btn_kept", btn, 4'b0010);
      check_output("chord_held", key_held, 1'b1);
      btn_raw = 4'd0;
      tick(12);
      check_output("chord_released", key_held, 1'b0);
      press_and_check(4'b0001, "repress");
      btn_raw = 4'd0;
      tick(12);
      check_output("chord_two_strobes", strobe_count - base, 2);

      // Button held through reset release
      btn_raw = 4'b1000;
      rst_n   = 1'b0;
      tick(2);
      rst_n = 1'b1;
      base  = strobe_count;
      tick(15);
      check_output("thru_rst_no_strobe", strobe_count - base, 0);
      check_output("thru_rst_not_held", key_held, 1'b0);
      btn_raw = 4'd0;
      tick(12);
      press_and_check(4'b0100, "thru_rst");
      btn_raw = 4'd0;
      tick(12);

      // Reset asserted mid-debounce
      base    = strobe_count;
      btn_raw = 4'b0010;
      tick(5);
      rst_n = 1'b0;
      #1;
      check_output("mid_rst_btn", btn, 4'd0);
      check_output("mid_rst_strobe", is_a_key_pressed, 1'b0);
      check_output("mid_rst_held", key_held, 1'b0);
      btn_raw = 4'd0;
      tick(2);
      rst_n = 1'b1;
      tick(14);
      check_output("mid_rst_no_strobe", strobe_count - base, 0);

      // Sequence of four presses feeding the lock
      strobe_codes.delete();
      press_and_check(4'b0100, "seq0");
      tick(4);
      btn_raw = 4'd0;
      tick(12);
      press_and_check(4'b0001, "seq1");
      tick(4);
      btn_raw = 4'd0;
      tick(12);
      press_and_check(4'b0010, "seq2");
      tick(4);
      btn_raw = 4'd0;
      tick(12);
      press_and_check(4'b0001, "seq3");
      tick(4);
      btn_raw = 4'd0;
      tick(12);
      check_output("seq_count", strobe_codes.size(), 4);
      if (strobe_codes.size() == 4) begin
         check_output("seq_code0", strobe_codes[0], 4'b0100);
         check_output("seq_code1", strobe_codes[1], 4'b0001);
         check_output("seq_code2", strobe_codes[2], 4'b0010);
         check_output("seq_code3", strobe_codes[3], 4'b0001);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
